result_quantizer: RTL
=====================

RESULT_QUANTIZER -- requirements
Module: result_quantizer

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: read latency in cycles from rd_addr/rd_en to valid rd_data_k; legal values 1..3.
REQ-002 SHALL have parameter N_C1, default 784: word count per channel when layer_c1=1.
REQ-003 SHALL have parameter N_CX, default 100: word count per channel when layer_c1=0.
REQ-004 SHALL have ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse that begins one readout pass.
- layer_c1  in  1  1 = C1 pass (N_C1 words, channels 0-5); 0 = later layer (N_CX words, channels 0-15); sampled at start.
- quant_shift  in  5  right-shift amount; sampled at start.
- relu_en  in  1  1 = clamp negatives to 0; sampled at start.
- rd_en  out  1  read strobe to the result RAMs.
- rd_addr  out  10  read address, shared by all 16 RAMs.
- rd_data_0..rd_data_15  in  32 each  signed RAM read data.
- q_data  out  128  16 signed int8 lanes; lane k in bits [8k+7:8k].
- q_addr  out  10  word index of q_data.
- q_valid  out  1  q_data/q_addr valid this cycle.
- busy  out  1  pass in progress.
- done  out  1  single-cycle pulse at end of pass.

Function
REQ-005 SHALL implement FSM IDLE -> READ -> DRAIN -> FIN -> IDLE.
REQ-006 In IDLE, start=1 SHALL latch layer_c1, quant_shift, relu_en, set N = N_C1 or N_CX, clear rd_addr to 0, and enter READ next cycle.
REQ-007 In READ, rd_en SHALL be 1 every cycle, with rd_addr incrementing by 1 per cycle from 0 to N-1; no stalls.
REQ-008 After rd_en with rd_addr=N-1, the FSM SHALL enter DRAIN with rd_en=0 and rd_addr held at N-1.
REQ-009 DRAIN SHALL last until the last q_valid has been output, then go to FIN.
REQ-010 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-011 busy SHALL be 1 in READ, DRAIN and FIN, and 0 in IDLE.
REQ-012 start while busy=1 SHALL be ignored with no effect on the current pass.
REQ-013 Data captured RD_LAT cycles after each rd_en SHALL pass through 2 pipeline stages; q_valid SHALL therefore be rd_en delayed RD_LAT+2 cycles, and q_addr the matching rd_addr delayed identically.
REQ-014 Stage 1 SHALL, per lane, for s=quant_shift: if s>0, r = (x + 2^(s-1)) >>> s, computed in 33-bit signed with no overflow; if s=0, r = x.
REQ-015 Stage 2 SHALL, per lane, saturate r to [-128,127]; when relu_en=1, negative results SHALL become 0.
REQ-016 When the latched layer_c1=1, lanes 6-15 of q_data SHALL be forced to 0x00 regardless of rd_data.
REQ-017 When q_valid=0, q_data SHALL hold its last value.
REQ-018 Exactly N q_valid pulses SHALL occur per pass, with q_addr strictly 0..N-1 in order.
REQ-019 done SHALL assert the cycle after the last q_valid.

Reset
REQ-020 rst_n=0 SHALL asynchronously force FSM=IDLE, and rd_en, rd_addr, q_data, q_addr, q_valid, busy, done, all pipeline valids and all latched configuration to 0.
REQ-021 Reset mid-pass SHALL abort the pass: no further q_valid or done; the next start after release SHALL begin a clean pass from address 0.

Verification
REQ-022 C1 pass, RD_LAT=1, shift=0, relu=0, rd_data_k = addr: first q_valid 4 cycles after start; q_addr 0..783; lane0 = min(addr,127); lanes 6-15 = 0; 784 q_valid pulses; done once.
REQ-023 Non-C1 pass, shift=4, relu=0: ch0 = 24 -> 2 (round half up); ch1 = -24 -> -1; ch2 = 0x7FFFFFFF -> 127; ch3 = 0x80000000 -> -128; exactly 100 q_valid pulses.
REQ-024 relu=1, shift=0, inputs -5 and 200 -> outputs 0 and 127.
REQ-025 start re-pulsed at cycle 50 of a C1 pass: ignored, still 784 beats and a single done.
REQ-026 rst_n low at beat 300 of a pass: all outputs 0 within the reset, no done; restart with layer_c1=0 yields 100 beats starting at q_addr 0.
REQ-027 RD_LAT=3 build: q_valid lags rd_en by exactly 5 cycles, with the same data as the RD_LAT=1 case.

Source files
------------

// File: rtl/result_quantizer.sv
// Result readout and int8 quantizer: streams N words from 16 result RAMs,
// rounds/shifts/saturates each 32-bit lane to int8 and emits 128-bit beats.

module result_quantizer_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s1_en_i,
  input  logic        s2_en_i,
  input  logic [31:0] x_i,
  input  logic [4:0]  shift_i,
  input  logic        relu_i,
  input  logic        zero_i,
  output logic [7:0]  q_o
);
  logic signed [32:0] xe, sum, r_d, r_q;
  logic [7:0]         q_d;

  // Stage 1 arithmetic: round-half-up right shift in 33 bits so x+2^(s-1) cannot overflow
  always_comb begin
    xe  = $signed({x_i[31], x_i});
    sum = xe + (33'sd1 <<< (shift_i - 5'd1));
    r_d = (shift_i == 5'd0) ? xe : (sum >>> shift_i);
  end

  // Stage 2 arithmetic: optional relu, saturate to int8, force unused lanes to zero
  always_comb begin
    if (zero_i || (relu_i && (r_q < 0)))  q_d = 8'h00;
    else if (r_q > 33'sd127)              q_d = 8'h7f;
    else if (r_q < -33'sd128)             q_d = 8'h80;
    else                                  q_d = r_q[7:0];
  end

  // Pipeline registers; q_o holds its value between valid beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      q_o <= '0;
    end else begin
      if (s1_en_i) r_q <= r_d;
      if (s2_en_i) q_o <= q_d;
    end
  end
endmodule

module result_quantizer #(
  parameter int RD_LAT = 1,
  parameter int N_C1   = 784,
  parameter int N_CX   = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         layer_c1,
  input  logic [4:0]   quant_shift,
  input  logic         relu_en,
  output logic         rd_en,
  output logic [9:0]   rd_addr,
  input  logic [31:0]  rd_data_0,
  input  logic [31:0]  rd_data_1,
  input  logic [31:0]  rd_data_2,
  input  logic [31:0]  rd_data_3,
  input  logic [31:0]  rd_data_4,
  input  logic [31:0]  rd_data_5,
  input  logic [31:0]  rd_data_6,
  input  logic [31:0]  rd_data_7,
  input  logic [31:0]  rd_data_8,
  input  logic [31:0]  rd_data_9,
  input  logic [31:0]  rd_data_10,
  input  logic [31:0]  rd_data_11,
  input  logic [31:0]  rd_data_12,
  input  logic [31:0]  rd_data_13,
  input  logic [31:0]  rd_data_14,
  input  logic [31:0]  rd_data_15,
  output logic [127:0] q_data,
  output logic [9:0]   q_addr,
  output logic         q_valid,
  output logic         busy,
  output logic         done
);
  localparam int NUM_LANES = 16;
  localparam int STAGES    = RD_LAT + 2;
  localparam logic [9:0] LAST_C1 = 10'(N_C1 - 1);
  localparam logic [9:0] LAST_CX = 10'(N_CX - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t                         state_q, state_d;
  logic [9:0]                     rd_addr_q, rd_addr_d, last_q;
  logic                           c1_q, relu_q;
  logic [4:0]                     shift_q;
  logic [STAGES:1]                vld_pipe;
  logic [STAGES:1][9:0]           addr_pipe;
  logic [NUM_LANES-1:0][31:0]     rd_data_w;
  logic [NUM_LANES-1:0][7:0]      lane_q;

  assign rd_data_w = {rd_data_15, rd_data_14, rd_data_13, rd_data_12,
                      rd_data_11, rd_data_10, rd_data_9,  rd_data_8,
                      rd_data_7,  rd_data_6,  rd_data_5,  rd_data_4,
                      rd_data_3,  rd_data_2,  rd_data_1,  rd_data_0};

  assign rd_en   = (state_q == READ);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);
  assign rd_addr = rd_addr_q;
  assign q_valid = vld_pipe[STAGES];
  assign q_addr  = addr_pipe[STAGES];
  assign q_data  = lane_q;

  // Next-state: read N words back to back, drain until the last beat leaves, pulse done
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE:  if (start) begin
               state_d   = READ;
               rd_addr_d = '0;
             end
      READ:  if (rd_addr_q == last_q) state_d = DRAIN;
             else                     rd_addr_d = rd_addr_q + 10'd1;
      DRAIN: if (q_valid && (q_addr == last_q)) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, read address and pass configuration (latched only on an accepted start)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      last_q    <= '0;
      c1_q      <= 1'b0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      if (state_q == IDLE && start) begin
        c1_q    <= layer_c1;
        shift_q <= quant_shift;
        relu_q  <= relu_en;
        last_q  <= layer_c1 ? LAST_C1 : LAST_CX;
      end
    end
  end

  // Valid/address shift registers tracking each read through RAM latency and 2 stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], rd_en};
      addr_pipe <= {addr_pipe[STAGES-1:1], rd_addr_q};
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    result_quantizer_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .s1_en_i (vld_pipe[RD_LAT]),
      .s2_en_i (vld_pipe[RD_LAT+1]),
      .x_i     (rd_data_w[k]),
      .shift_i (shift_q),
      .relu_i  (relu_q),
      .zero_i  (c1_q && (k >= 6)),
      .q_o     (lane_q[k])
    );
  end
endmodule
